// File: rtl/serial_pkg.sv
// Shared types for the serial transmitter family: FSM states and parity modes.
package serial_pkg;

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop
    } t_serial_tx_state;

    typedef enum logic [1:0] {
        ParityNone,
        ParityEven,
        ParityOdd
    } t_parity;

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous show-ahead word FIFO with wrap-bit pointers; head is valid whenever !empty.
module serial_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Full/empty come from registered pointers only, so a pop cannot make room for a same-cycle push.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/serial_async_tx_buf.sv
// Buffered UART-style transmitter: FIFO of words streamed back-to-back onto out_serial.
// Parity support is compiled in only when SERIAL_TX_PARITY_EN is defined.
module serial_async_tx_buf
    import serial_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int LOWBIT_FIRST  = 1,
    parameter int MAIN_CLK_HZ   = 50_000_000,
    parameter int SERIAL_CLK_HZ = 9600,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_enable,
    input  logic [BITS-1:0]               in_parallel,
    input  logic                          in_valid,
    output logic                          out_wr_ready,
    output logic                          out_serial,
    output logic                          out_next_word,
    output logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   out_level
);

    localparam int DIV      = MAIN_CLK_HZ / SERIAL_CLK_HZ;
    localparam int STOP_CYC = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_CYC);
    localparam int BW       = $clog2(BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(BITS - 1);

    if (DIV < 2 || BITS < 5 || BITS > 16 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY < 0 || PARITY > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("serial_async_tx_buf: illegal parameters (DIV=%0d must be >= 2)", DIV);
    end

`ifdef SERIAL_TX_PARITY_EN
    localparam t_parity PAR_MODE = t_parity'(PARITY);
    localparam bit      PAR_ON   = (PAR_MODE != ParityNone);
    logic par_q, par_d;
`endif

    t_serial_tx_state state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [BITS-1:0]  shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             next_word_q, next_word_d;
    logic             ready_q, ready_d;

    logic             fifo_pop, fifo_empty, fifo_full;
    logic [BITS-1:0]  fifo_head;
    logic             start_ok, load, data_bit;

    serial_tx_fifo #(
        .WIDTH (BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (in_clk),
        .rst       (in_rst),
        .push      (in_valid),
        .push_data (in_parallel),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (out_level)
    );

    assign start_ok = !fifo_empty && in_enable;
    assign data_bit = (LOWBIT_FIRST != 0) ? shift_q[0] : shift_q[BITS-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        next_word_d = 1'b0;
        load        = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            Idle: begin
                cnt_d = '0;
                load  = start_ok;
            end
            Start: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = Data;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            Data: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    shift_d = (LOWBIT_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                    if (bit_q == DATA_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PAR_ON ? Parity : Stop;
`else
                        state_d = Stop;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            Parity: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = Stop;
                    cnt_d   = '0;
                end
            end
`endif
            Stop: begin
                if (cnt_q == STOP_LAST) begin
                    next_word_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = Idle;
                    load        = start_ok;
                end
            end
            default: begin
                state_d = Idle;
                cnt_d   = '0;
            end
        endcase

        // Popping straight into Start from Stop is what keeps frames gap-free.
        if (load) begin
            state_d = Start;
            cnt_d   = '0;
            shift_d = fifo_head;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = (^fifo_head) ^ (PAR_MODE == ParityOdd);
`endif
        end
        fifo_pop = load;
    end

    // Line level is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            Start:   serial_d = 1'b0;
            Data:    serial_d = data_bit;
`ifdef SERIAL_TX_PARITY_EN
            Parity:  serial_d = par_q;
`endif
            default: serial_d = 1'b1;
        endcase
        ready_d = (state_q == Idle) && fifo_empty && !(in_valid && !fifo_full);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= Idle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            serial_q    <= 1'b1;
            next_word_q <= 1'b0;
            ready_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            serial_q    <= serial_d;
            next_word_q <= next_word_d;
            ready_q     <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign out_serial    = serial_q;
    assign out_next_word = next_word_q;
    assign out_ready     = ready_q;
    assign out_wr_ready  = !fifo_full;

endmodule

// File: tb/tb_serial_async_tx_buf.sv
// Scoreboard bench for serial_async_tx_buf at DIV=4: a line monitor decodes frames and checks them against queued words.
module tb_serial_async_tx_buf;

    localparam int DIV  = 4;
    localparam int BITS = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int STOP     = 2;
`else
    localparam int PAR_BITS = 0;
    localparam int STOP     = 1;
`endif
    localparam int SLOTS     = 1 + BITS + PAR_BITS + STOP;
    localparam int FRAME_LEN = DIV * SLOTS;
    localparam int LW        = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic            valid = 1'b0;
    logic            m_valid = 1'b0;
    logic [BITS-1:0] parallel = '0;
    logic [BITS-1:0] m_parallel = '0;
    logic            wr_ready, serial, next_word, ready;
    logic [LW-1:0]   level;
    logic            m_wr_ready, m_serial, m_next_word, m_ready;
    logic [LW-1:0]   m_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int push_cyc = 0;
    int rx_frames = 0;
    int nw_pulses = 0;
    int m_nw_pulses = 0;
    int gap_sum = 0;
    int last_end = 0;
    int last_start = 0;
    bit burst_first = 1'b1;
    logic [BITS-1:0] sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && next_word) nw_pulses <= nw_pulses + 1;
    always @(negedge clk) if (!rst && m_next_word) m_nw_pulses <= m_nw_pulses + 1;

    serial_async_tx_buf #(
        .BITS(BITS), .LOWBIT_FIRST(1), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000),
        .STOP_BITS(STOP), .PARITY(1), .FIFO_DEPTH(4)
    ) u_dut (
        .in_clk(clk), .in_rst(rst), .in_enable(enable), .in_parallel(parallel), .in_valid(valid),
        .out_wr_ready(wr_ready), .out_serial(serial), .out_next_word(next_word),
        .out_ready(ready), .out_level(level)
    );

    serial_async_tx_buf #(
        .BITS(BITS), .LOWBIT_FIRST(0), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000),
        .STOP_BITS(STOP), .PARITY(1), .FIFO_DEPTH(4)
    ) u_dut_msb (
        .in_clk(clk), .in_rst(rst), .in_enable(1'b1), .in_parallel(m_parallel), .in_valid(m_valid),
        .out_wr_ready(m_wr_ready), .out_serial(m_serial), .out_next_word(m_next_word),
        .out_ready(m_ready), .out_level(m_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_frame();
        logic            smp [FRAME_LEN];
        logic            nwp [FRAME_LEN];
        logic [BITS-1:0] word;
        logic [BITS-1:0] exp_w;
        logic            v;
        bit              shape_ok;
        bit              nw_ok;
        int              start_c;
        start_c  = cyc;
        shape_ok = 1'b1;
        nw_ok    = 1'b1;
        word     = '0;
        exp_w    = '0;
        smp[0]   = serial;
        nwp[0]   = next_word;
        for (int i = 1; i < FRAME_LEN; i++) begin
            @(negedge clk);
            if (rst) return;
            smp[i] = serial;
            nwp[i] = next_word;
        end
        for (int s = 0; s < SLOTS; s++) begin
            v = smp[s*DIV];
            for (int k = 1; k < DIV; k++) if (smp[s*DIV+k] !== v) shape_ok = 1'b0;
            if (s == 0) begin
                if (v !== 1'b0) shape_ok = 1'b0;
            end else if (s <= BITS) begin
                word[s-1] = v;
            end else if (s > BITS + PAR_BITS) begin
                if (v !== 1'b1) shape_ok = 1'b0;
            end
        end
        for (int i = 0; i < FRAME_LEN; i++) if (nwp[i] !== 1'(i == FRAME_LEN - 1)) nw_ok = 1'b0;
        check_eq("rx_expected", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) exp_w = sb_q.pop_front();
        check_eq("rx_data", 32'(word), 32'(exp_w));
        check_eq("rx_shape", 32'(shape_ok), 32'(1));
        check_eq("rx_next_word", 32'(nw_ok), 32'(1));
`ifdef SERIAL_TX_PARITY_EN
        check_eq("rx_parity", 32'(smp[(BITS+1)*DIV]), 32'(^exp_w));
`endif
        $display("frame %0d: data=%02h expected=%02h start_cyc=%0d", rx_frames, word, exp_w, start_c);
        if (!burst_first) gap_sum = gap_sum + (start_c - last_end - 1);
        burst_first = 1'b0;
        last_start  = start_c;
        last_end    = cyc;
        rx_frames++;
    endtask

    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (!rst && serial === 1'b0) rx_frame();
        end
    end

    task automatic push_word(input logic [BITS-1:0] w, input bit exp_acc);
        @(negedge clk);
        check_eq("wr_ready", 32'(wr_ready), 32'(exp_acc));
        parallel = w;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        push_cyc = cyc;
        if (exp_acc) sb_q.push_back(w);
    endtask

    task automatic push_done();
        @(negedge clk);
        valid    = 1'b0;
        parallel = BITS'($urandom);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (rx_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("frames_done", 32'(rx_frames >= target), 32'(1));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int nw0;
        int n;
        logic [BITS-1:0] line;
        logic [LW-1:0] exp_lvl [4];
        exp_lvl[0] = 3'd1; exp_lvl[1] = 3'd1; exp_lvl[2] = 3'd2; exp_lvl[3] = 3'd3;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_serial", 32'(serial), 32'(1));
        check_eq("rst_next_word", 32'(next_word), 32'(0));
        check_eq("rst_ready", 32'(ready), 32'(1));
        check_eq("rst_wr_ready", 32'(wr_ready), 32'(1));
        check_eq("rst_level", 32'(level), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 8N1 frame of 8'h10: start bit two edges after the push
        push_word(8'h10, 1'b1);
        check_eq("busy_after_push", 32'(ready), 32'(0));
        push_done();
        wait_frames(1, 200);
        check_eq("latency", 32'(last_start), 32'(push_cyc + 2));
        repeat (2) @(negedge clk);
        check_eq("ready_after_frame", 32'(ready), 32'(1));
        check_eq("level_after_frame", 32'(level), 32'(0));
        check_eq("nw_count_single", 32'(nw_pulses), 32'(1));

        // Back-to-back burst; the first word leaves the FIFO one edge after its push
        base = rx_frames;
        nw0  = nw_pulses;
        gap_sum = 0;
        burst_first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: push_word(8'hff, 1'b1);
                1: push_word(8'h11, 1'b1);
                2: push_word(8'h01, 1'b1);
                default: push_word(8'h10, 1'b1);
            endcase
            check_eq("level_b2b", 32'(level), 32'(exp_lvl[i]));
        end
        push_done();
        wait_frames(base + 4, 4 * FRAME_LEN + 50);
        repeat (3) @(negedge clk);
        check_eq("b2b_gaps", 32'(gap_sum), 32'(0));
        check_eq("b2b_nw_count", 32'(nw_pulses - nw0), 32'(4));
        check_eq("b2b_level_end", 32'(level), 32'(0));

        // Full FIFO with transmission disabled; fifth push must be dropped
        @(negedge clk);
        enable = 1'b0;
        push_word(8'ha1, 1'b1);
        push_word(8'hb2, 1'b1);
        push_word(8'hc3, 1'b1);
        push_word(8'hd4, 1'b1);
        push_word(8'he5, 1'b0);
        push_done();
        check_eq("full_level", 32'(level), 32'(4));
        check_eq("full_wr_ready", 32'(wr_ready), 32'(0));
        base = rx_frames;
        repeat (50) @(negedge clk);
        check_eq("held_while_disabled", 32'(rx_frames), 32'(base));
        enable = 1'b1;
        burst_first = 1'b1;
        gap_sum = 0;
        wait_frames(base + 4, 4 * FRAME_LEN + 50);
        repeat (FRAME_LEN + 10) @(negedge clk);
        check_eq("full_frames", 32'(rx_frames), 32'(base + 4));
        check_eq("full_gaps", 32'(gap_sum), 32'(0));
        check_eq("full_sb_empty", 32'(sb_q.size()), 32'(0));

        // Parity-bearing word (parity bit 1 when parity is compiled in)
        push_word(8'h01, 1'b1);
        push_done();
        wait_frames(base + 5, 200);

        // Disable mid-frame: current frame completes, second word stays queued
        base = rx_frames;
        push_word(8'h3c, 1'b1);
        push_word(8'h7e, 1'b1);
        push_done();
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_frames(base + 1, 200);
        repeat (2 * FRAME_LEN) @(negedge clk);
        check_eq("disable_frames", 32'(rx_frames), 32'(base + 1));
        check_eq("disable_level", 32'(level), 32'(1));
        enable = 1'b1;
        wait_frames(base + 2, 200);

        // MSB-first instance: 8'h01 appears as seven zeros then a one
        repeat (FRAME_LEN) @(negedge clk);
        check_eq("msb_wr_ready", 32'(m_wr_ready), 32'(1));
        m_parallel = 8'h01;
        m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        m_parallel = 8'hfe;
        n = 0;
        while (m_serial !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("msb_start_seen", 32'(m_serial), 32'(0));
        line = '0;
        repeat (DIV) @(negedge clk);
        for (int b = 0; b < BITS; b++) begin
            line = {line[BITS-2:0], m_serial};
            repeat (DIV) @(negedge clk);
        end
        $display("msb frame: line bits=%08b expected=00000001", line);
        check_eq("msb_line", 32'(line), 32'(8'h01));
        repeat ((STOP + PAR_BITS) * DIV + 4) @(negedge clk);
        check_eq("msb_nw_count", 32'(m_nw_pulses), 32'(1));
        check_eq("msb_ready", 32'(m_ready), 32'(1));
        check_eq("msb_level", 32'(m_level), 32'(0));

        // Reset in the middle of a data bit with two words queued
        base = rx_frames;
        push_word(8'h00, 1'b1);
        push_word(8'h55, 1'b1);
        push_word(8'h66, 1'b1);
        push_done();
        while (cyc < push_cyc + 2 + DIV + 6) @(negedge clk);
        check_eq("pre_rst_line", 32'(serial), 32'(0));
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_serial", 32'(serial), 32'(1));
        check_eq("mid_rst_level", 32'(level), 32'(0));
        check_eq("mid_rst_ready", 32'(ready), 32'(1));
        sb_q.delete();
        nw0 = nw_pulses;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME_LEN) @(negedge clk);
        check_eq("post_rst_frames", 32'(rx_frames), 32'(base));
        check_eq("post_rst_nw", 32'(nw_pulses), 32'(nw0));
        check_eq("post_rst_serial", 32'(serial), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
